// File: rtl/fp_mul_seq.sv
// rtl/fp_mul_seq.sv - multi-cycle IEEE-754 multiplier, shift-add significand engine, RNE rounding
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake; in1, in2 captured on accept
//   out_valid/out_ready result handshake; out and flags held while out_valid
//   flags               {invalid, overflow, underflow, inexact}
module fp_mul_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in1,
    input  logic [EXP_W+MAN_W:0]   in2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out,
    output logic [3:0]             flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M  = MAN_W + 1;          // significand width with hidden one
    localparam int P  = 2 * M;              // full product width
    localparam int CW = $clog2(M + 1);
    localparam int XW = EXP_W + 2;          // exponent working width, two's complement

    localparam logic [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]  QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_MULT,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t            state;
    logic [W-1:0]      a_r;
    logic [W-1:0]      b_r;
    logic              sign_r;
    logic [M-1:0]      mcand;
    logic [P-1:0]      prod;
    logic [CW-1:0]     cnt;
    logic [XW-1:0]     exp_r;
    logic [MAN_W-1:0]  man_r;
    logic              guard_r;
    logic              sticky_r;

    // Operand field decode from the captured operands.
    logic [EXP_W-1:0]  ea, eb;
    logic [MAN_W-1:0]  ma, mb;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic              sign_ab, snan;
    logic [XW-1:0]     exp_sum;

    assign ea      = a_r[W-2:MAN_W];
    assign eb      = b_r[W-2:MAN_W];
    assign ma      = a_r[MAN_W-1:0];
    assign mb      = b_r[MAN_W-1:0];
    assign a_nan   = (&ea) && (|ma);
    assign b_nan   = (&eb) && (|mb);
    assign a_inf   = (&ea) && !(|ma);
    assign b_inf   = (&eb) && !(|mb);
    // A zero exponent means zero: denormals are flushed and their mantissa ignored.
    assign a_zero  = !(|ea);
    assign b_zero  = !(|eb);
    assign sign_ab = a_r[W-1] ^ b_r[W-1];
    assign snan    = (a_nan && !ma[MAN_W-1]) || (b_nan && !mb[MAN_W-1]);
    assign exp_sum = {2'b00, ea} + {2'b00, eb} - BIAS;

    // One shift-add step: the low half of prod holds the remaining multiplier
    // bits, consumed LSB first while the partial sum shifts in from the top.
    logic [M:0]        add_sum;
    logic [P-1:0]      prod_step;

    assign add_sum   = {1'b0, prod[P-1:M]} + (prod[0] ? {1'b0, mcand} : {(M+1){1'b0}});
    assign prod_step = {add_sum, prod[M-1:1]};

    // Normalisation: the product of two [1,2) significands lies in [1,4).
    logic [MAN_W-1:0]  man_n;
    logic              guard_n;
    logic              sticky_n;

    assign man_n    = prod[P-1] ? prod[P-2 -: MAN_W] : prod[P-3 -: MAN_W];
    assign guard_n  = prod[P-1] ? prod[MAN_W] : prod[MAN_W-1];
    assign sticky_n = prod[P-1] ? (|prod[MAN_W-1:0]) : (|prod[MAN_W-2:0]);

    // Round to nearest even; a carry out of the mantissa leaves it all zero
    // and bumps the exponent.
    logic              rnd_up;
    logic [MAN_W:0]    man_inc;
    logic [XW-1:0]     exp_fin;
    logic              ovf;
    logic              udf;
    logic              inexact;

    assign rnd_up  = guard_r && (sticky_r || man_r[0]);
    assign man_inc = {1'b0, man_r} + {{MAN_W{1'b0}}, rnd_up};
    assign exp_fin = exp_r + {{(XW-1){1'b0}}, man_inc[MAN_W]};
    assign ovf     = !exp_fin[XW-1] && (exp_fin >= EMAX);
    assign udf     = exp_fin[XW-1] || (exp_fin == {XW{1'b0}});
    assign inexact = guard_r || sticky_r;

    assign in_ready = (state == S_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out       <= '0;
            flags     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_r   <= in1;
                        b_r   <= in2;
                        state <= S_UNPACK;
                    end
                end

                S_UNPACK: begin
                    sign_r <= sign_ab;
                    if (a_nan || b_nan) begin
                        out   <= QNAN;
                        flags <= {snan, 3'b000};
                        state <= S_DONE;
                    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
                        out   <= QNAN;
                        flags <= 4'b1000;
                        state <= S_DONE;
                    end else if (a_inf || b_inf) begin
                        out   <= {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flags <= 4'b0000;
                        state <= S_DONE;
                    end else if (a_zero || b_zero) begin
                        out   <= {sign_ab, {(W-1){1'b0}}};
                        flags <= 4'b0000;
                        state <= S_DONE;
                    end else begin
                        mcand <= {1'b1, ma};
                        prod  <= {{M{1'b0}}, 1'b1, mb};
                        exp_r <= exp_sum;
                        cnt   <= '0;
                        state <= S_MULT;
                    end
                end

                S_MULT: begin
                    prod <= prod_step;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(M - 1)) begin
                        state <= S_NORM;
                    end
                end

                S_NORM: begin
                    man_r    <= man_n;
                    guard_r  <= guard_n;
                    sticky_r <= sticky_n;
                    exp_r    <= exp_r + {{(XW-1){1'b0}}, prod[P-1]};
                    state    <= S_ROUND;
                end

                S_ROUND: begin
                    if (ovf) begin
                        out   <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flags <= 4'b0101;
                    end else if (udf) begin
                        out   <= {sign_r, {(W-1){1'b0}}};
                        flags <= 4'b0011;
                    end else begin
                        out   <= {sign_r, exp_fin[EXP_W-1:0], man_inc[MAN_W-1:0]};
                        flags <= {3'b000, inexact};
                    end
                    state <= S_DONE;
                end

                S_DONE: begin
                    // First DONE cycle raises out_valid; the result then waits for out_ready.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb/tb_fp_mul_seq.sv - directed vector bench for fp_mul_seq (binary32 and binary16 instances)
module tb_fp_mul_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in1, in2, out;
    logic [3:0]  flags;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_in1, h_in2, h_out;
    logic [3:0]  h_flags;

    fp_mul_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .flags(flags)
    );

    fp_mul_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst),
        .in_valid(h_in_valid), .in_ready(h_in_ready),
        .in1(h_in1), .in2(h_in2),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .out(h_out), .flags(h_flags)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
    } vec_t;

    vec_t vecs[16];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in1      = $urandom;
        in2      = $urandom;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 200);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, c0, c1, seen;

        vecs[0]  = '{32'h40000000, 32'h3F800000, 32'h40000000, 4'h0, 28};
        vecs[1]  = '{32'h40200000, 32'h40600000, 32'h410C0000, 4'h0, 28};
        vecs[2]  = '{32'hFF800000, 32'h7F800000, 32'hFF800000, 4'h0, 2};
        vecs[3]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'h8, 2};
        vecs[4]  = '{32'hFF800001, 32'h44FC7333, 32'h7FC00000, 4'h8, 2};
        vecs[5]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 4'h0, 2};
        vecs[6]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'h5, 28};
        vecs[7]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'h3, 28};
        vecs[8]  = '{32'h00400000, 32'h40000000, 32'h00000000, 4'h0, 2};
        vecs[9]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'h1, 28};
        vecs[10] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'h1, 28};
        vecs[11] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'h0, 2};
        vecs[12] = '{32'h3FC00000, 32'h3F800001, 32'h3FC00002, 4'h1, 28};
        vecs[13] = '{32'h3FC00000, 32'h3F800003, 32'h3FC00004, 4'h1, 28};
        vecs[14] = '{32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 4'h1, 28};
        vecs[15] = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'h0, 28};

        rst         = 1'b1;
        in_valid    = 1'b0;
        in1         = '0;
        in2         = '0;
        out_ready   = 1'b1;
        h_in_valid  = 1'b0;
        h_in1       = '0;
        h_in2       = '0;
        h_out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out", {32'd0, out}, 64'd0);
        chk("rst_flags", {60'd0, flags}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_h_out_valid", {63'd0, h_out_valid}, 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Vector table
        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_valid(lat);
            chk($sformatf("v%0d_out", i), {32'd0, out}, {32'd0, vecs[i].res});
            chk($sformatf("v%0d_flags", i), {60'd0, flags}, {60'd0, vecs[i].flg});
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid_drop", i), {63'd0, out_valid}, 64'd0);
        end

        // Back-pressure: result held for 5 cycles, then transferred
        out_ready = 1'b0;
        start_op(32'h40200000, 32'h40600000);
        wait_valid(lat);
        chk("bp_latency", 64'(lat), 64'd28);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d_valid", k), {63'd0, out_valid}, 64'd1);
            chk($sformatf("bp_hold%0d_out", k), {32'd0, out}, 64'h410C0000);
            chk($sformatf("bp_hold%0d_flags", k), {60'd0, flags}, 64'd0);
            chk($sformatf("bp_hold%0d_in_ready", k), {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_transfer_valid", {63'd0, out_valid}, 64'd0);
        chk("bp_in_ready_after", {63'd0, in_ready}, 64'd1);

        // Back-to-back: in_valid held high, accepts spaced latency+2 apart
        in1      = 32'h40000000;
        in2      = 32'h40000000;
        in_valid = 1'b1;
        c0 = -1;
        c1 = -1;
        for (int c = 0; c < 100 && c1 < 0; c++) begin
            @(negedge clk);
            if (in_ready) begin
                if (c0 < 0) c0 = c;
                else        c1 = c;
            end
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        chk("b2b_period", 64'(c1 - c0), 64'd30);
        wait_valid(lat);
        chk("b2b_out", {32'd0, out}, 64'h40800000);
        @(posedge clk);
        #1;

        // Reset mid-MULT aborts the operation
        start_op(32'h40000000, 32'h40000000);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready_low", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_in_ready_high", {63'd0, in_ready}, 64'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        chk("midrst_no_valid", 64'(seen), 64'd0);
        start_op(32'h40000000, 32'h40000000);
        wait_valid(lat);
        chk("midrst_next_out", {32'd0, out}, 64'h40800000);
        chk("midrst_next_latency", 64'(lat), 64'd28);
        @(posedge clk);
        #1;

        // binary16 instance
        @(negedge clk);
        lat = 0;
        while (!h_in_ready && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        h_in1      = 16'h4000;
        h_in2      = 16'h4000;
        h_in_valid = 1'b1;
        @(posedge clk);
        #1;
        h_in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!h_out_valid && lat < 200);
        chk("h_out", {48'd0, h_out}, 64'h4400);
        chk("h_flags", {60'd0, h_flags}, 64'd0);
        chk("h_latency", 64'(lat), 64'd15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_mul_seq.md
# fp_mul_seq

Parametrised, multi-cycle IEEE-754 floating-point multiplier with valid/ready handshakes on both sides. It replaces the combinational binary32 multiplier in the floating-point datapath. Exponent and mantissa widths are generic, so one block serves binary16, binary32 and binary64. It adds round-to-nearest-even, exception flags and back-pressure, and computes the significand product with an iterative shift-add engine of one bit per cycle.

## Interface
- EXP_W, default 8: exponent field width (≥ 3).
- MAN_W, default 23: stored mantissa field width (≥ 2); word width is W = 1+EXP_W+MAN_W.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands; high only in IDLE with rst low.
- in1  in  W  operand A (sign, exponent, mantissa).
- in2  in  W  operand B.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- out  out  W  product.
- flags  out  4  {invalid, overflow, underflow, inexact}, valid with out.

## Operation
- Accept: in1/in2 are captured on an edge where in_valid && in_ready. One operation is in flight at a time.
- FSM states:
  - IDLE: accept → UNPACK.
  - UNPACK: special → DONE; otherwise → MULT.
  - MULT: runs MAN_W+1 cycles → NORM.
  - NORM → ROUND → DONE.
  - DONE: out_ready → IDLE.
- Unpack: sign = sA^sB. Exponent all-zero is treated as zero: denormal inputs are flushed to zero, mantissa ignored.
- Special cases (bias B = 2^(EXP_W-1)-1), in priority order:
  - Either operand NaN → canonical qNaN (sign 0, exponent all ones, mantissa MSB 1, rest 0). invalid=1 only if the NaN is signalling (mantissa MSB 0).
  - Inf×0 → canonical qNaN, invalid=1.
  - Inf×finite or Inf×Inf → Inf with sign = sA^sB.
  - Zero×finite → zero with sign = sA^sB.
- MULT: shift-add of the two (MAN_W+1)-bit significands (hidden 1 restored), one multiplier bit per cycle, into a 2·(MAN_W+1)-bit product.
- Exponent: eA+eB−B, computed signed on EXP_W+2 bits.
- NORM: if product MSB is set, shift right 1 and increment the exponent. Keep MAN_W mantissa bits, a guard bit, and a sticky bit (OR of all lower bits).
- ROUND: round-to-nearest-even; round up when guard && (sticky || lsb). A mantissa carry-out renormalises (exponent +1, mantissa 0).
- inexact = guard || sticky.
- Overflow: final exponent ≥ 2^EXP_W−1 → Inf with sign = sA^sB, overflow=1, inexact=1.
- Underflow: final exponent ≤ 0 → signed zero (flush), underflow=1, inexact=1.

## Timing
- Reset values: state IDLE, out_valid 0, out 0, flags 0. in_ready is 0 while rst is high and 1 on the first cycle after rst deasserts.
- Reset mid-operation aborts the operation; no result is produced.
- Latency: out_valid rises on the 2nd rising edge after the accepting edge for special cases, and on the (MAN_W+5)th edge for normal operands (28 for binary32).
- out and flags are registered. They are stable while out_valid is high and out_ready is low.
- Handshake: a result transfers on an edge with out_valid && out_ready. out_valid drops on that edge.
- in_ready is low in DONE, so no new operand is accepted on the same edge as the output transfer. The earliest next accept is one cycle later.
- Throughput is one result per latency+2 cycles with out_ready held high.
- in_valid is ignored outside IDLE. Operand changes while busy have no effect.

## Test plan
- Basic products: 0x40000000×0x3F800000 → 0x40000000; 0x40200000×0x40600000 (2.5×3.5) → 0x410C0000, flags 0; out_valid exactly 28 cycles after the accept.
- Specials:
  - 0xFF800000×0x7F800000 → 0xFF800000.
  - 0x7F800000×0x00000000 → 0x7FC00000, invalid.
  - 0xFF800001×0x44FC7333 → 0x7FC00000, invalid, latency 2.
  - 0x80000000×0x3F800000 → 0x80000000.
- Range:
  - 0x7F000000×0x40000000 → 0x7F800000, overflow and inexact.
  - 0x00800000×0x3F000000 → 0x00000000, underflow and inexact.
  - 0x00400000×0x40000000 → 0x00000000 (denormal flushed).
- Rounding: 0x3F800001×0x3F800001 → 0x3F800002, inexact. 0x3FFFFFFF×0x3FFFFFFF → 0x407FFFFE, inexact.
- Back-pressure:
  - Hold out_ready low for 5 cycles after out_valid. out and flags must stay stable, in_ready must stay 0, and a transfer occurs on the first edge with out_ready high.
  - Back-to-back ops: in_ready rises exactly one cycle after the transfer.
- Reset and parameters:
  - Assert rst for 1 cycle in mid-MULT. out_valid must never assert, in_ready is 1 the next cycle, and the following op (2×2) gives 0x40800000.
  - Re-run with EXP_W=5, MAN_W=10: 0x4000×0x4000 → 0x4400 after 15 cycles.
